vga_sync_receiver: RTL

VGA timing receiver and pixel capture block: the receive-side counterpart of the VGA output path. It samples `hsync`, `vsync` and 8-bit `RGB` on pixel strobes and recovers column and row coordinates. It checks line and frame periods against the configured mode and declares lock after consecutive good frames. While locked, it emits one valid pixel per active-area strobe. It sits in loopback/self-test builds, fed directly from the signal generator outputs in the same `clk` domain.

---
 rtl/vga_sync_receiver.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
//
// Receive-side VGA timing recovery and pixel capture. Samples hsync, vsync
// and RGB on pixel strobes, rebuilds the column/line position, checks every
// line and frame period against the configured mode, and declares lock after
// LOCK_FRAMES consecutive good frames. While locked, each active-area strobe
// produces one registered pixel with its coordinates.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   pix_en       pixel strobe; nothing advances on cycles where it is low
//   hsync        horizontal sync, active low
//   vsync        vertical sync, active low
//   RGB          8-bit pixel colour
//   pixel_valid  one-cycle pulse, captured pixel valid
//   pixel_data   captured colour (held until the next valid pixel)
//   col          column of pixel_data, 0..H_ACTIVE-1
//   row          row of pixel_data, 0..V_ACTIVE-1
//   frame_start  one-cycle pulse one cycle after a sampled vsync rise
//   locked       timing lock status
//   timing_err   one-cycle pulse on a line/frame period mismatch while locked

module vga_sync_receiver #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BACK      = 48,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_BACK      = 33,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] RGB,
  output logic       pixel_valid,
  output logic [7:0] pixel_data,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_err
);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_START   = 10'(H_BACK);
  localparam logic [9:0] H_END     = 10'(H_BACK + H_ACTIVE);
  localparam logic [9:0] V_LINES   = 10'(V_TOTAL);
  // lines counts from 1 on the first line of a frame, so the active window
  // is offset by one from V_BACK.
  localparam logic [9:0] V_START   = 10'(V_BACK + 1);
  localparam logic [9:0] V_END     = 10'(V_BACK + V_ACTIVE + 1);
  localparam logic [9:0] CNT_MAX   = 10'h3FF;
  localparam logic [2:0] LOCK_N    = 3'(LOCK_FRAMES);

  state_t     state;
  logic       hs_d;
  logic       vs_d;
  logic [9:0] h_cnt;
  logic [9:0] lines;
  logic       lines_ok;
  logic [2:0] good_cnt;

  logic       hs_rise;
  logic       vs_rise;
  logic       line_bad;
  logic       frame_good;
  logic [9:0] h_next;
  logic [9:0] lines_next;
  logic       active;

  // Edge detection, next counter values and the period checks. The position
  // of the pixel sampled on a strobe is the post-update counter value, so the
  // strobe carrying the hsync rise is column position 0. The frame check
  // looks at the pre-update line count, and a line closing on the same strobe
  // as the vsync rise still belongs to the frame being judged.
  always_comb begin
    hs_rise    = pix_en & ~hs_d & hsync;
    vs_rise    = pix_en & ~vs_d & vsync;
    line_bad   = hs_rise & (h_cnt != H_LAST);
    frame_good = (lines == V_LINES) & lines_ok & ~line_bad;

    h_next = h_cnt;
    if (hs_rise)
      h_next = '0;
    else if (h_cnt != CNT_MAX)
      h_next = h_cnt + 10'd1;

    lines_next = lines;
    if (vs_rise)
      lines_next = hs_rise ? 10'd1 : 10'd0;
    else if (hs_rise && lines != CNT_MAX)
      lines_next = lines + 10'd1;

    active = (h_next >= H_START) && (h_next < H_END) &&
             (lines_next >= V_START) && (lines_next < V_END);
  end

  // Counters, lock FSM and all registered outputs. Pulses clear every cycle
  // and are only re-asserted on strobes. Pixel capture is gated by the state
  // held before this strobe, so a pixel sampled on the strobe that reveals a
  // bad line is still delivered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEARCH;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      h_cnt       <= '0;
      lines       <= '0;
      lines_ok    <= 1'b1;
      good_cnt    <= '0;
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
      col         <= '0;
      row         <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
      if (pix_en) begin
        hs_d        <= hsync;
        vs_d        <= vsync;
        h_cnt       <= h_next;
        lines       <= lines_next;
        frame_start <= vs_rise;

        if (vs_rise)
          lines_ok <= 1'b1;
        else if (line_bad)
          lines_ok <= 1'b0;

        if (state == LOCKED && active) begin
          pixel_valid <= 1'b1;
          pixel_data  <= RGB;
          col         <= h_next - H_START;
          row         <= lines_next - V_START;
        end

        case (state)
          SEARCH: begin
            if (vs_rise) begin
              good_cnt <= '0;
              state    <= ALIGN;
            end
          end
          ALIGN: begin
            if (vs_rise) begin
              if (frame_good) begin
                good_cnt <= good_cnt + 3'd1;
                if (good_cnt + 3'd1 == LOCK_N) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                good_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if (line_bad || (vs_rise && !frame_good)) begin
              timing_err <= 1'b1;
              locked     <= 1'b0;
              state      <= SEARCH;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
